// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART core.
//   - parity mode constants (PAR_NONE / PAR_EVEN / PAR_ODD)
//   - TX and RX state encodings
//   - parity_bit(): parity bit for a data word under a given mode
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Data is passed zero-extended to 9 bits; the extra zeros do not change
  // the XOR, so one function serves every DATA_BITS setting.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator.
//   clk   - master clock
//   rst_n - synchronous active-low reset
//   clr   - reload the counter (no tick on that cycle)
//   tick  - one-cycle pulse every CLK_DIV cycles
module uart_baud_tick #(
  parameter int CLK_DIV = 1302
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_reg <= RELOAD;
    end else if (cnt_reg == '0) begin
      cnt_reg <= RELOAD;
    end else begin
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign tick = (cnt_reg == '0) && !clr;

endmodule

// File: rtl/uart_core.sv
// uart_core: parametrised UART transceiver.
//   clk, rst_n            - master clock, synchronous active-low reset
//   rx / tx               - serial pins, idle high
//   tx_valid/tx_data/tx_ready - transmit handshake; tx_busy while a frame is out
//   rx_valid              - one-cycle strobe per received frame
//   rx_data               - last received word, held until next rx_valid
//   rx_parity_err/rx_frame_err - error flags qualified by rx_valid
//   rx_busy               - receiver not idle
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 1302,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  // ---------------------------------------------------------------- TX
  tx_state_t            tx_state_reg, tx_state_next;
  logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
  logic                 tx_par_reg, tx_par_next;
  logic [BW-1:0]        tx_bit_reg, tx_bit_next;
  logic                 tx_stop_reg, tx_stop_next;
  logic [TW-1:0]        tx_os_reg, tx_os_next;
  logic                 tx_reg, tx_next;
  logic                 tx_clr, tx_tick, tx_bit_end;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tx_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tx_clr),
    .tick (tx_tick)
  );

  assign tx_bit_end = tx_tick && (tx_os_reg == OS_LAST);

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_shift_next = tx_shift_reg;
    tx_par_next   = tx_par_reg;
    tx_bit_next   = tx_bit_reg;
    tx_stop_next  = tx_stop_reg;
    tx_os_next    = tx_os_reg;
    tx_clr        = 1'b0;
    tx_next       = 1'b1;
    if (tx_tick) begin
      tx_os_next = (tx_os_reg == OS_LAST) ? '0 : tx_os_reg + TW'(1);
    end
    case (tx_state_reg)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_shift_next = tx_data;
          tx_par_next   = parity_bit(9'(tx_data), PARITY);
          tx_clr        = 1'b1;
          tx_os_next    = '0;
          tx_bit_next   = '0;
          tx_stop_next  = 1'b0;
          tx_state_next = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) tx_state_next = TX_DATA;
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_next = tx_shift_reg >> 1;
          if (tx_bit_reg == BIT_LAST) begin
            tx_state_next = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
          end else begin
            tx_bit_next = tx_bit_reg + BW'(1);
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) tx_state_next = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_stop_reg == STOP_LAST) tx_state_next = TX_IDLE;
          else tx_stop_next = 1'b1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
    // Line level is registered from the next state so the pin never glitches.
    case (tx_state_next)
      TX_START:  tx_next = 1'b0;
      TX_DATA:   tx_next = tx_shift_next[0];
      TX_PARITY: tx_next = tx_par_next;
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_bit_reg   <= '0;
      tx_stop_reg  <= 1'b0;
      tx_os_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_shift_reg <= tx_shift_next;
      tx_par_reg   <= tx_par_next;
      tx_bit_reg   <= tx_bit_next;
      tx_stop_reg  <= tx_stop_next;
      tx_os_reg    <= tx_os_next;
      tx_reg       <= tx_next;
    end
  end

  assign tx       = tx_reg;
  assign tx_ready = (tx_state_reg == TX_IDLE);
  assign tx_busy  = !tx_ready;

  // ---------------------------------------------------------------- RX
  logic [1:0]           rx_sync_reg;
  logic                 rx_s;
  rx_state_t            rx_state_reg, rx_state_next;
  logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic                 rx_par_reg, rx_par_next;
  logic [BW-1:0]        rx_bit_reg, rx_bit_next;
  logic [TW-1:0]        rx_os_reg, rx_os_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
  logic                 rx_perr_reg, rx_perr_next;
  logic                 rx_ferr_reg, rx_ferr_next;
  logic                 rx_clr, rx_tick, rx_mid, rx_half;

  always_ff @(posedge clk) begin
    if (!rst_n) rx_sync_reg <= 2'b11;
    else        rx_sync_reg <= {rx_sync_reg[0], rx};
  end
  assign rx_s = rx_sync_reg[1];

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_rx_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (rx_clr),
    .tick (rx_tick)
  );

  // rx_half lands mid start bit; every later sample is a full bit further on.
  assign rx_mid  = rx_tick && (rx_os_reg == OS_LAST);
  assign rx_half = rx_tick && (rx_os_reg == HALF_LAST);

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_shift_next = rx_shift_reg;
    rx_par_next   = rx_par_reg;
    rx_bit_next   = rx_bit_reg;
    rx_os_next    = rx_os_reg;
    rx_valid_next = 1'b0;
    rx_data_next  = rx_data_reg;
    rx_perr_next  = rx_perr_reg;
    rx_ferr_next  = rx_ferr_reg;
    rx_clr        = 1'b0;
    if (rx_tick) begin
      rx_os_next = (rx_os_reg == OS_LAST) ? '0 : rx_os_reg + TW'(1);
    end
    case (rx_state_reg)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_clr        = 1'b1;
          rx_os_next    = '0;
          rx_bit_next   = '0;
          rx_state_next = RX_START;
        end
      end
      RX_START: begin
        if (rx_half) begin
          rx_os_next    = '0;
          rx_state_next = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_mid) begin
          rx_shift_next = {rx_s, rx_shift_reg[DATA_BITS-1:1]};
          if (rx_bit_reg == BIT_LAST) begin
            rx_state_next = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
          end else begin
            rx_bit_next = rx_bit_reg + BW'(1);
          end
        end
      end
      RX_PARITY: begin
        if (rx_mid) begin
          rx_par_next   = rx_s;
          rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_mid) begin
          rx_valid_next = 1'b1;
          rx_data_next  = rx_shift_reg;
          rx_perr_next  = (PARITY != PAR_NONE) &&
                          (rx_par_reg != parity_bit(9'(rx_shift_reg), PARITY));
          rx_ferr_next  = !rx_s;
          // A low stop bit parks in WAIT_HIGH so a held break yields one strobe.
          rx_state_next = rx_s ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_reg <= RX_IDLE;
      rx_shift_reg <= '0;
      rx_par_reg   <= 1'b0;
      rx_bit_reg   <= '0;
      rx_os_reg    <= '0;
      rx_valid_reg <= 1'b0;
      rx_data_reg  <= '0;
      rx_perr_reg  <= 1'b0;
      rx_ferr_reg  <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_shift_reg <= rx_shift_next;
      rx_par_reg   <= rx_par_next;
      rx_bit_reg   <= rx_bit_next;
      rx_os_reg    <= rx_os_next;
      rx_valid_reg <= rx_valid_next;
      rx_data_reg  <= rx_data_next;
      rx_perr_reg  <= rx_perr_next;
      rx_ferr_reg  <= rx_ferr_next;
    end
  end

  assign rx_valid      = rx_valid_reg;
  assign rx_data       = rx_data_reg;
  assign rx_parity_err = rx_perr_reg;
  assign rx_frame_err  = rx_ferr_reg;
  assign rx_busy       = (rx_state_reg != RX_IDLE);

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: three uart_core instances (parity none / even / odd, the even
// one with two stop bits) driven with randomized frames and compared against
// a frame-level model built from the line format.
module tb_uart_core;

  localparam int CLK_DIV = 4;
  localparam int OS      = 16;
  localparam int BIT_CYC = CLK_DIV * OS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] tx_w, tx_valid_w, tx_ready_w, tx_busy_w;
  logic [2:0] rx_w, rx_valid_w, rx_perr_w, rx_ferr_w, rx_busy_w;
  logic [2:0] rx_drv = 3'b111;
  logic [2:0] loop_en = 3'b000;
  logic       rx_abort = 1'b0;
  logic [7:0] tx_data_w [3];
  logic [7:0] rx_data_w [3];

  int         rx_cnt [3] = '{0, 0, 0};
  logic [7:0] rx_last_data [3];
  logic       rx_last_perr [3];
  logic       rx_last_ferr [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    assign rx_w[gi] = loop_en[gi] ? tx_w[gi] : rx_drv[gi];
    uart_core #(
      .CLK_DIV   (CLK_DIV),
      .OVERSAMPLE(OS),
      .DATA_BITS (8),
      .PARITY    (gi),
      .STOP_BITS ((gi == 1) ? 2 : 1)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx_w[gi]),
      .tx           (tx_w[gi]),
      .tx_valid     (tx_valid_w[gi]),
      .tx_data      (tx_data_w[gi]),
      .tx_ready     (tx_ready_w[gi]),
      .tx_busy      (tx_busy_w[gi]),
      .rx_valid     (rx_valid_w[gi]),
      .rx_data      (rx_data_w[gi]),
      .rx_parity_err(rx_perr_w[gi]),
      .rx_frame_err (rx_ferr_w[gi]),
      .rx_busy      (rx_busy_w[gi])
    );
  end

  // Strobe monitor
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rx_valid_w[k] === 1'b1) begin
        rx_cnt[k]       <= rx_cnt[k] + 1;
        rx_last_data[k] <= rx_data_w[k];
        rx_last_perr[k] <= rx_perr_w[k];
        rx_last_ferr[k] <= rx_ferr_w[k];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic int stops_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int par, input int stops);
    return 1 + 8 + ((par != 0) ? 1 : 0) + stops;
  endfunction

  // Bit i = line level during bit period i of the frame (unused bits are 1).
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int par,
                                             input bit bad_par, input bit stop_low);
    logic [15:0] f;
    int          pos;
    int          ones;
    logic        pbit;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = d[i];
    pos = 9;
    if (par != 0) begin
      ones = $countones(d);
      pbit = (par == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
      f[pos] = bad_par ? ~pbit : pbit;
      pos++;
    end
    if (stop_low) f[pos] = 1'b0;
    return f;
  endfunction

  // ---------------------------------------------------------------- TX
  task automatic tx_frame(input int k, input logic [7:0] d);
    int          nbits, bad, waited;
    logic [15:0] exp, obs;
    logic        last_ready;
    nbits = frame_len(k, stops_of(k));
    exp   = frame_bits(d, k, 1'b0, 1'b0);
    @(posedge clk); #1;
    waited = 0;
    while (tx_ready_w[k] !== 1'b1 && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("tx_ready_wait", 32'(tx_ready_w[k]), 1);
    tx_valid_w[k] = 1'b1;
    tx_data_w[k]  = d;
    @(posedge clk); #1;
    tx_valid_w[k] = 1'b0;
    tx_data_w[k]  = 8'($urandom);
    obs = '1;
    bad = 0;
    last_ready = 1'b1;
    for (int c = 0; c < nbits * BIT_CYC; c++) begin
      @(negedge clk);
      if (tx_w[k] !== exp[c / BIT_CYC]) bad++;
      if (c % BIT_CYC == BIT_CYC / 2) obs[c / BIT_CYC] = tx_w[k];
      if (c == nbits * BIT_CYC - 1) last_ready = tx_ready_w[k];
    end
    @(negedge clk);
    check_eq("tx_bits", 32'(obs), 32'(exp));
    check_eq("tx_bad_cycles", bad, 0);
    check_eq("tx_ready_last_bit", 32'(last_ready), 0);
    check_eq("tx_ready_after", 32'(tx_ready_w[k]), 1);
    $display("tx[%0d] frame 0x%02h bits=%0d wave_errs=%0d", k, d, nbits, bad);
  endtask

  // ---------------------------------------------------------------- RX
  task automatic drive_rx(input int k, input logic [7:0] d, input bit bad_par,
                          input bit stop_low, input int hold_bits, output logic busy_end);
    int          nbits;
    logic [15:0] f;
    nbits = frame_len(k, 1);
    f     = frame_bits(d, k, bad_par, stop_low);
    busy_end = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < (nbits + hold_bits) * BIT_CYC; c++) begin
      if (rx_abort) begin
        rx_drv[k] = 1'b1;
        return;
      end
      rx_drv[k] = (c / BIT_CYC < nbits) ? f[c / BIT_CYC] : 1'b0;
      @(posedge clk); #1;
    end
    busy_end  = rx_busy_w[k];
    rx_drv[k] = 1'b1;
  endtask

  task automatic rx_frame_check(input int k, input logic [7:0] d, input bit bad_par);
    int   cnt0;
    logic busy_end;
    cnt0 = rx_cnt[k];
    drive_rx(k, d, bad_par, 1'b0, 0, busy_end);
    repeat (2 * BIT_CYC) @(posedge clk);
    @(negedge clk);
    check_eq("rx_strobes", rx_cnt[k] - cnt0, 1);
    check_eq("rx_data", 32'(rx_last_data[k]), 32'(d));
    check_eq("rx_parity_err", 32'(rx_last_perr[k]), 32'(bad_par && (k != 0)));
    check_eq("rx_frame_err", 32'(rx_last_ferr[k]), 0);
    check_eq("rx_busy_idle", 32'(rx_busy_w[k]), 0);
    $display("rx[%0d] frame 0x%02h bad_par=%0d got 0x%02h perr=%0d ferr=%0d",
             k, d, bad_par, rx_last_data[k], rx_last_perr[k], rx_last_ferr[k]);
  endtask

  task automatic loop_check(input int k, input logic [7:0] d);
    int cnt0;
    cnt0 = rx_cnt[k];
    loop_en[k] = 1'b1;
    tx_frame(k, d);
    repeat (BIT_CYC) @(posedge clk);
    @(negedge clk);
    check_eq("loop_strobes", rx_cnt[k] - cnt0, 1);
    check_eq("loop_data", 32'(rx_last_data[k]), 32'(d));
    check_eq("loop_parity_err", 32'(rx_last_perr[k]), 0);
    check_eq("loop_frame_err", 32'(rx_last_ferr[k]), 0);
    loop_en[k] = 1'b0;
    $display("loop[%0d] frame 0x%02h received 0x%02h", k, d, rx_last_data[k]);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    logic [7:0] d;
    int         k, cnt0;
    logic       busy_end;
    tx_valid_w = 3'b000;
    for (int i = 0; i < 3; i++) tx_data_w[i] = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_tx", 32'(tx_w[i]), 1);
      check_eq("rst_tx_ready", 32'(tx_ready_w[i]), 1);
      check_eq("rst_tx_busy", 32'(tx_busy_w[i]), 0);
      check_eq("rst_rx_valid", 32'(rx_valid_w[i]), 0);
      check_eq("rst_rx_data", 32'(rx_data_w[i]), 0);
      check_eq("rst_rx_errs", 32'({rx_perr_w[i], rx_ferr_w[i]}), 0);
      check_eq("rst_rx_busy", 32'(rx_busy_w[i]), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Directed: 8N1 transmit of 0xA5
    tx_frame(0, 8'hA5);
    // Directed: even-parity loopback of 0x3C
    loop_check(1, 8'h3C);
    // Directed: odd parity, wrong parity bit on 0x81
    rx_frame_check(2, 8'h81, 1'b1);

    // Stop bit low, line held low for 5 bit periods
    cnt0 = rx_cnt[0];
    d = 8'($urandom);
    drive_rx(0, d, 1'b0, 1'b1, 5, busy_end);
    @(negedge clk);
    check_eq("brk_busy_held", 32'(busy_end), 1);
    check_eq("brk_strobes", rx_cnt[0] - cnt0, 1);
    check_eq("brk_frame_err", 32'(rx_last_ferr[0]), 1);
    check_eq("brk_parity_err", 32'(rx_last_perr[0]), 0);
    check_eq("brk_data", 32'(rx_last_data[0]), 32'(d));
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("brk_busy_release", 32'(rx_busy_w[0]), 0);
    $display("rx[0] break after 0x%02h strobes=%0d", d, rx_cnt[0] - cnt0);
    rx_frame_check(0, 8'h55, 1'b0);

    // Short low glitch on rx
    cnt0 = rx_cnt[0];
    @(posedge clk); #1;
    rx_drv[0] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("glitch_busy_seen", 32'(rx_busy_w[0]), 1);
    repeat (10) @(posedge clk);
    #1 rx_drv[0] = 1'b1;
    repeat (25) @(posedge clk);
    @(negedge clk);
    check_eq("glitch_busy_clear", 32'(rx_busy_w[0]), 0);
    repeat (3 * BIT_CYC) @(posedge clk);
    check_eq("glitch_strobes", rx_cnt[0] - cnt0, 0);
    $display("rx[0] glitch of 20 cycles strobes=%0d", rx_cnt[0] - cnt0);

    // Reset mid TX data bit 3 and mid RX data bit 5
    cnt0 = rx_cnt[0];
    fork
      begin
        logic be;
        drive_rx(0, 8'($urandom), 1'b0, 1'b0, 0, be);
      end
      begin
        repeat (126) @(posedge clk);
        #1;
        tx_valid_w[0] = 1'b1;
        tx_data_w[0]  = 8'($urandom);
        @(posedge clk); #1;
        tx_valid_w[0] = 1'b0;
        repeat (4 * BIT_CYC + BIT_CYC / 2) @(posedge clk);
        #2;
        rst_n     = 1'b0;
        rx_abort  = 1'b1;
        rx_drv[0] = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_tx", 32'(tx_w[0]), 1);
        check_eq("mid_rst_tx_ready", 32'(tx_ready_w[0]), 1);
        check_eq("mid_rst_rx_busy", 32'(rx_busy_w[0]), 0);
        check_eq("mid_rst_rx_valid", 32'(rx_valid_w[0]), 0);
      end
    join
    rx_abort = 1'b0;
    repeat (12 * BIT_CYC) @(posedge clk);
    check_eq("mid_rst_strobes", rx_cnt[0] - cnt0, 0);
    $display("reset mid-frame strobes=%0d", rx_cnt[0] - cnt0);
    tx_frame(0, 8'h0F);

    // Randomized loopback and direct-drive frames
    repeat (6) begin
      k = int'($urandom_range(0, 2));
      loop_check(k, 8'($urandom));
    end
    repeat (6) begin
      k = int'($urandom_range(0, 2));
      rx_frame_check(k, 8'($urandom), (k != 0) && ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
